lsu_mem_responder: RTL
======================

// Module: lsu_mem_responder
// PURPOSE
//  Executes the load/store operations that the CU's reg_write_en/mem_write_en enables request.
//  Each accepted operation becomes a req/ack transaction on the data-memory port.
//  Load results are written back to the register file.
//  Sits between CU + register-file read ports and data memory; stalls issue while busy.
// PARAMETERS
//  DATA_W   16  data word width (register and memory)
//  ADDR_W    8  data-memory address width
//  REG_AW    4  register index width (matches instr field width)
//  TIMEOUT  15  max cycles waiting for mem_ack (used only with LSU_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst_n        in   1       synchronous active-low reset
//  issue_valid  in   1       operation offered this cycle
//  issue_ready  out  1       block can accept (high only in IDLE)
//  instr        in   16      [3:0] opcode, [7:4] rd/rs, [11:8] base, [15:12] imm4 offset
//  reg_write_en in   1       from CU: load requested
//  mem_write_en in   1       from CU: store requested
//  base_data    in   DATA_W  value of register instr[11:8]
//  src_data     in   DATA_W  value of register instr[7:4] (store data)
//  mem_req      out  1       memory request, held until mem_ack
//  mem_we       out  1       1 = write, 0 = read; stable while mem_req
//  mem_addr     out  ADDR_W  access address; stable while mem_req
//  mem_wdata    out  DATA_W  store data; stable while mem_req
//  mem_ack      in   1       memory completes the request this cycle
//  mem_rdata    in   DATA_W  read data, valid with mem_ack
//  rf_we        out  1       register writeback strobe (one cycle)
//  rf_waddr     out  REG_AW  writeback register index
//  rf_wdata     out  DATA_W  writeback data
//  done         out  1       one-cycle pulse when an operation retires
//  err          out  1       one-cycle pulse with done on illegal/aborted operation
// BEHAVIOUR
//  Reset: state=IDLE; mem_req, mem_we, rf_we, done, err = 0; mem_addr, mem_wdata, rf_waddr, rf_wdata = 0.
//  All outputs are registered except issue_ready = (state==IDLE).
//  Accept: issue_valid && issue_ready. Capture rd, opcode, mem_addr = (base_data + zero-ext imm4) mod 2^ADDR_W.
//   Address wraps around; no overflow flag. mem_wdata = src_data.
//  Operation select at accept:
//   mem_write_en=1, reg_write_en=0 -> STORE
//   reg_write_en=1, mem_write_en=0 -> LOAD
//   both 0 -> NOP: done pulse next cycle, no memory access
//   both 1 -> illegal: done+err pulse next cycle, no memory access
//  FSM IDLE -> REQ (load/store): mem_req=1 from cycle after accept.
//  REQ: on mem_ack, drop mem_req next edge.
//   Store -> IDLE, done pulses on that same edge.
//   Load -> capture mem_rdata into rf_wdata -> WB.
//  WB: rf_we=1, rf_waddr=rd for exactly one cycle with done; then -> IDLE.
//  Latency, ack in first REQ cycle:
//   store: accept T, mem_req at T+1, done at T+2.
//   load: rf_we/done at T+3.
//  Next issue is accepted in the cycle done is high (state already IDLE).
//  mem_ack while not in REQ is ignored. mem_rdata is sampled only with mem_ack.
//  Reset mid-operation: next edge returns to IDLE with mem_req=0; the pending op is lost, no done.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//   - Counter clears on entering REQ.
//   - If no mem_ack after TIMEOUT cycles in REQ: drop mem_req, pulse done+err, go IDLE, no writeback.
//   - An ack arriving in the same cycle as expiry wins, giving a normal completion.
//  Not defined: REQ waits indefinitely; err pulses only for illegal enables.
// STRUCTURE
//  tisc_pkg:
//   - OP_LOAD=4'b0000, OP_STORE=4'b0001
//   - instr field bit positions
//   - lsu_state_t enum {IDLE, REQ, WB}
//  Sub-module lsu_timeout_ctr (counter + expiry flag), instantiated only under LSU_TIMEOUT_EN.
// TESTING
//  Store: base=0x10, imm=3, src=0xBEEF, ack 2 cycles after req.
//   -> mem_addr=0x13, mem_we=1, mem_wdata=0xBEEF stable until ack; done 1 cycle after ack; rf_we never.
//  Load: rd=5, base=0x20, imm=0, ack same cycle as req with rdata=0x1234.
//   -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 at T+3.
//  Wrap: base=0x00FE, imm=4 -> mem_addr=0x02.
//  Enables both 1 -> done+err pulse at T+1, mem_req stays 0.
//  Enables both 0 -> done only.
//  rst_n low while in REQ -> mem_req=0 next edge, no done.
//   Following load completes normally.
//  LSU_TIMEOUT_EN, ack never arrives:
//   -> mem_req drops and done+err pulse after 15 REQ cycles.
//   With ack at cycle 15 -> normal completion, err=0.

Source files
------------

// File: rtl/lsu_mem_responder_pkg.sv
// Shared definitions for the load/store responder: opcodes, instruction field
// layout and the FSM state encoding.
package tisc_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned FIELD_W = 4;

    localparam logic [FIELD_W-1:0] OP_LOAD  = 4'b0000;
    localparam logic [FIELD_W-1:0] OP_STORE = 4'b0001;

    // Instruction field LSB positions
    localparam int unsigned F_OP_LSB   = 0;
    localparam int unsigned F_RD_LSB   = 4;
    localparam int unsigned F_BASE_LSB = 8;
    localparam int unsigned F_IMM_LSB  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_mem_responder_if.sv
// Data-memory request/acknowledge port.
//   master: drives mem_req/mem_we/mem_addr/mem_wdata, receives mem_ack/mem_rdata
//   slave : the memory side of the same handshake
interface lsu_mem_responder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_responder_timeout_ctr.sv
// Watchdog for an outstanding memory request (built into the responder only
// when LSU_TIMEOUT_EN is defined).
//   clk, rst_n   : clock, synchronous active-low reset
//   i_clear      : restart the count (request being issued)
//   i_run        : request outstanding this cycle
//   o_expired_c  : combinational, high in the TIMEOUT-th running cycle
module lsu_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired_c
);
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Count holds at TIMEOUT-1 so the flag stays up until the FSM leaves REQ
    assign o_expired_c = i_run && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && !o_expired_c) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/lsu_mem_responder.sv
// Load/store responder: turns CU load/store enables into one data-memory
// req/ack transaction and writes load results back to the register file.
// Optional feature macro: LSU_TIMEOUT_EN (abort a request after TIMEOUT cycles).
//   clk, rst_n                 : clock, synchronous active-low reset
//   issue_valid / issue_ready  : operation handshake (ready only in IDLE)
//   instr, reg_write_en, mem_write_en, base_data, src_data : operation inputs
//   mem                        : data-memory port (master side)
//   rf_we, rf_waddr, rf_wdata  : register writeback
//   done, err                  : retire pulse and error flag
module lsu_mem_responder
    import tisc_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  reg_write_en,
    input  logic                  mem_write_en,
    input  logic [DATA_W-1:0]     base_data,
    input  logic [DATA_W-1:0]     src_data,
    lsu_mem_responder_if.master   mem,
    output logic                  rf_we,
    output logic [REG_AW-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  done,
    output logic                  err
);
    lsu_state_t r_state, w_state_nxt;

    logic              r_is_load,   w_is_load;
    logic [REG_AW-1:0] r_rd,        w_rd;
    logic              r_mem_req,   w_mem_req;
    logic              r_mem_we,    w_mem_we;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
    logic              r_rf_we,     w_rf_we;
    logic [REG_AW-1:0] r_rf_waddr,  w_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata,  w_rf_wdata;
    logic              r_done,      w_done;
    logic              r_err,       w_err;

    logic              w_accept;
    logic              w_op_load;
    logic              w_op_store;
    logic              w_op_mem;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_eff_addr;
    logic              w_unused_fields;

    assign issue_ready = (r_state == IDLE);
    assign w_accept    = issue_valid && (r_state == IDLE);
    assign w_op_load   = reg_write_en && !mem_write_en;
    assign w_op_store  = mem_write_en && !reg_write_en;
    assign w_op_mem    = w_op_load || w_op_store;

    // Base + zero-extended imm4, truncated to the memory address width (wraps)
    assign w_eff_addr = ADDR_W'(base_data + DATA_W'(instr[F_IMM_LSB +: FIELD_W]));

    // Opcode and base index are not needed: the CU enables select the operation
    // and the base register value arrives on base_data.
    assign w_unused_fields = ^{instr[F_OP_LSB +: FIELD_W], instr[F_BASE_LSB +: FIELD_W]};

`ifdef LSU_TIMEOUT_EN
    lsu_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_accept && w_op_mem),
        .i_run       (r_state == REQ),
        .o_expired_c (w_timeout)
    );
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an ack in the expiry cycle takes priority
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept && w_op_mem) w_state_nxt = REQ;
            REQ: begin
                if (mem.mem_ack) begin
                    w_state_nxt = r_is_load ? WB : IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            WB:      w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_is_load   = r_is_load;
        w_rd        = r_rd;
        w_mem_req   = r_mem_req;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_rf_waddr  = r_rf_waddr;
        w_rf_wdata  = r_rf_wdata;
        w_rf_we     = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_is_load   = w_op_load;
                    w_rd        = instr[F_RD_LSB +: REG_AW];
                    w_mem_addr  = w_eff_addr;
                    w_mem_wdata = src_data;
                    w_mem_we    = w_op_store;
                    w_mem_req   = w_op_mem;
                    // NOP and illegal (both enables) retire without touching memory
                    w_done      = !w_op_mem;
                    w_err       = reg_write_en && mem_write_en;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    w_mem_req = 1'b0;
                    if (r_is_load) begin
                        w_rf_wdata = mem.mem_rdata;
                    end else begin
                        w_done = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_mem_req = 1'b0;
                    w_done    = 1'b1;
                    w_err     = 1'b1;
                end
            end
            WB: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = r_rd;
                w_done     = 1'b1;
            end
            default: begin
                w_mem_req = 1'b0;
            end
        endcase
    end

    // Output and operation registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_load   <= 1'b0;
            r_rd        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_is_load   <= w_is_load;
            r_rd        <= w_rd;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_rf_we     <= w_rf_we;
            r_rf_waddr  <= w_rf_waddr;
            r_rf_wdata  <= w_rf_wdata;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign rf_we         = r_rf_we;
    assign rf_waddr      = r_rf_waddr;
    assign rf_wdata      = r_rf_wdata;
    assign done          = r_done;
    assign err           = r_err;
endmodule
